uart_tx_sched: RTL and testbench

UART_TX_SCHED -- requirements
Module: uart_tx_sched

---
 rtl/uart_tx_sched.sv | 129 ++++++++++++
 tb/tb_uart_tx_sched.sv | 231 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_sched.sv
`default_nettype none
// uart_tx_sched: merges single echo bytes and zero-terminated buffered messages onto one UART tx stream.
// Optional: define TX_SCHED_INTERLEAVE_EN to let echo bytes slip between message bytes.
module uart_tx_sched #(
  parameter int MAX_LEN = 512,
  parameter int LEN_W   = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [7:0]       echo_data,
  input  logic             echo_valid,
  output logic             echo_ready,
  input  logic             msg_start,
  output logic [LEN_W-1:0] msg_addr,
  input  logic [7:0]       msg_byte,
  output logic             msg_busy,
  output logic             msg_done,
  output logic [7:0]       tx_data,
  output logic             tx_data_valid,
  input  logic             tx_data_ready
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ECHO      = 2'd1,
    MSG_FETCH = 2'd2,
    MSG_SEND  = 2'd3
  } state_t;

  localparam logic [LEN_W-1:0] ADDR_LIMIT = LEN_W'(MAX_LEN);
  localparam logic             GRANT_ECHO = 1'b0;
  localparam logic             GRANT_MSG  = 1'b1;

  state_t state;
  logic   msg_pend;
  logic   last_grant;
  logic   grant_echo;
  logic   grant_msg;
  logic   msg_accept;
  logic   tx_fire;
  logic   msg_end;

  // Round-robin only matters on contention; a lone requester always wins.
  always_comb begin
    grant_echo = 1'b0;
    grant_msg  = 1'b0;
    if (state == IDLE) begin
      if (echo_valid && msg_pend) begin
        grant_echo = (last_grant == GRANT_MSG);
        grant_msg  = (last_grant == GRANT_ECHO);
      end else begin
        grant_echo = echo_valid;
        grant_msg  = msg_pend;
      end
    end
  end

  assign echo_ready = rst_n & grant_echo;
  assign msg_accept = msg_start & ~msg_busy;
  assign tx_fire    = tx_data_valid & tx_data_ready;
  assign msg_end    = (msg_byte == 8'h00) || (msg_addr == ADDR_LIMIT);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      tx_data       <= 8'h00;
      tx_data_valid <= 1'b0;
      msg_addr      <= '0;
      msg_busy      <= 1'b0;
      msg_pend      <= 1'b0;
      msg_done      <= 1'b0;
      last_grant    <= GRANT_ECHO;
    end else begin
      msg_done <= 1'b0;
      if (msg_accept) begin
        msg_pend <= 1'b1;
        msg_busy <= 1'b1;
        msg_addr <= '0;
      end
      case (state)
        IDLE: begin
          if (grant_echo) begin
            tx_data       <= echo_data;
            tx_data_valid <= 1'b1;
            last_grant    <= GRANT_ECHO;
            state         <= ECHO;
          end else if (grant_msg) begin
            last_grant <= GRANT_MSG;
            state      <= MSG_FETCH;
          end
        end
        ECHO: begin
          if (tx_fire) begin
            tx_data_valid <= 1'b0;
            state         <= IDLE;
          end
        end
        MSG_FETCH: begin
          if (msg_end) begin
            msg_done <= 1'b1;
            msg_pend <= 1'b0;
            msg_busy <= 1'b0;
            state    <= IDLE;
          end else begin
            tx_data       <= msg_byte;
            tx_data_valid <= 1'b1;
            state         <= MSG_SEND;
          end
        end
        MSG_SEND: begin
          if (tx_fire) begin
            tx_data_valid <= 1'b0;
            if (msg_addr != ADDR_LIMIT) begin
              msg_addr <= msg_addr + LEN_W'(1);
            end
`ifdef TX_SCHED_INTERLEAVE_EN
            state <= IDLE;
`else
            state <= MSG_FETCH;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_sched.sv
`default_nettype none
// tb_uart_tx_sched: directed self-checking bench for uart_tx_sched.
module tb_uart_tx_sched;

  localparam int MAX_LEN = 512;
  localparam int LEN_W   = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [7:0]       echo_data = 8'h00;
  logic             echo_valid = 1'b0;
  logic             echo_ready;
  logic             msg_start = 1'b0;
  logic [LEN_W-1:0] msg_addr;
  logic [7:0]       msg_byte;
  logic             msg_busy;
  logic             msg_done;
  logic [7:0]       tx_data;
  logic             tx_data_valid;
  logic             tx_data_ready = 1'b1;

  logic [7:0] mem [0:1023];
  logic [7:0] txq [$];
  int         done_cnt = 0;
  int         vectors = 0;
  int         miscompares = 0;

  assign msg_byte = mem[msg_addr];

  uart_tx_sched #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .echo_data     (echo_data),
    .echo_valid    (echo_valid),
    .echo_ready    (echo_ready),
    .msg_start     (msg_start),
    .msg_addr      (msg_addr),
    .msg_byte      (msg_byte),
    .msg_busy      (msg_busy),
    .msg_done      (msg_done),
    .tx_data       (tx_data),
    .tx_data_valid (tx_data_valid),
    .tx_data_ready (tx_data_ready)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n && tx_data_valid && tx_data_ready) txq.push_back(tx_data);
    if (rst_n && msg_done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic clear_mem();
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
  endtask

  task automatic pulse_start();
    msg_start = 1'b1;
    @(negedge clk);
    msg_start = 1'b0;
  endtask

  task automatic wait_done(input int budget, output int cycles);
    cycles = 0;
    while (cycles < budget) begin
      @(negedge clk);
      cycles++;
      if (msg_done) break;
    end
  endtask

  task automatic wait_bytes(input int n, input int budget);
    int c;
    c = 0;
    while (txq.size() < n && c < budget) begin
      @(negedge clk);
      c++;
    end
  endtask

  initial begin
    int cyc;
    int all55;
    int found;
    int dsave;
    logic [7:0] exp_seq [6];

    clear_mem();

    // Reset state
    @(negedge clk);
    #1;
    chk("rst_tx_data", 32'(tx_data), 32'h00);
    chk("rst_tx_valid", 32'(tx_data_valid), 32'd0);
    chk("rst_echo_ready", 32'(echo_ready), 32'd0);
    chk("rst_msg_addr", 32'(msg_addr), 32'd0);
    chk("rst_busy_done", {30'd0, msg_busy, msg_done}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Echo accept and hold under backpressure
    tx_data_ready = 1'b0;
    echo_data  = 8'h41;
    echo_valid = 1'b1;
    #1;
    chk("echo_ready_idle", 32'(echo_ready), 32'd1);
    @(negedge clk);
    echo_data = 8'h42;
    #1;
    chk("echo_ready_in_echo", 32'(echo_ready), 32'd0);
    chk("echo_tx_first", {23'd0, tx_data_valid, tx_data}, {23'd0, 1'b1, 8'h41});
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("echo_hold", {23'd0, tx_data_valid, tx_data, echo_ready}, {23'd0, 1'b1, 8'h41, 1'b0});
    end
    tx_data_ready = 1'b1;
    echo_valid = 1'b0;
    @(negedge clk);
    chk("echo_valid_drop", 32'(tx_data_valid), 32'd0);
    chk("echo_sent", {txq.size() == 1 ? 24'd1 : 24'd0, txq.size() > 0 ? txq[0] : 8'h00}, {24'd1, 8'h41});

    // "HI\0" message
    txq.delete();
    done_cnt = 0;
    mem[0] = 8'h48; mem[1] = 8'h49; mem[2] = 8'h00;
    pulse_start();
    chk("hi_busy", 32'(msg_busy), 32'd1);
    wait_done(50, cyc);
    chk("hi_done_latency", 32'(cyc), 32'd6);
    chk("hi_done_addr", 32'(msg_addr), 32'd2);
    chk("hi_busy_low", 32'(msg_busy), 32'd0);
    chk("hi_count", 32'(txq.size()), 32'd2);
    if (txq.size() == 2) chk("hi_bytes", {16'd0, txq[0], txq[1]}, {16'd0, 8'h48, 8'h49});
    @(negedge clk);
    chk("hi_done_once", 32'(done_cnt), 32'd1);

    // msg_start while busy is ignored
    txq.delete();
    done_cnt = 0;
    pulse_start();
    @(negedge clk);
    @(negedge clk);
    pulse_start();
    wait_done(50, cyc);
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("dup_done_once", 32'(done_cnt), 32'd1);
    chk("dup_bytes", 32'(txq.size()), 32'd2);
    chk("dup_no_restart", {30'd0, msg_busy, 1'b0} | 32'(msg_addr), 32'd2);

    // Full-length message saturating at MAX_LEN
    txq.delete();
    done_cnt = 0;
    for (int i = 0; i <= MAX_LEN; i++) mem[i] = 8'h55;
    pulse_start();
    wait_done(5000, cyc);
    chk("full_done_seen", 32'(msg_done), 32'd1);
    chk("full_count", 32'(txq.size()), 32'd512);
    chk("full_addr", 32'(msg_addr), 32'd512);
    all55 = 1;
    foreach (txq[i]) if (txq[i] !== 8'h55) all55 = 0;
    chk("full_bytes", 32'(all55), 32'd1);
    @(negedge clk);
    chk("full_done_once", 32'(done_cnt), 32'd1);

    // Message vs continuous echo, from a fresh reset so the message wins first
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    clear_mem();
    mem[0] = 8'h41; mem[1] = 8'h42; mem[2] = 8'h43; mem[3] = 8'h00;
    txq.delete();
    done_cnt = 0;
    pulse_start();
    echo_data  = 8'h7A;
    echo_valid = 1'b1;
`ifdef TX_SCHED_INTERLEAVE_EN
    exp_seq = '{8'h41, 8'h7A, 8'h42, 8'h7A, 8'h43, 8'h7A};
`else
    exp_seq = '{8'h41, 8'h42, 8'h43, 8'h7A, 8'h7A, 8'h7A};
`endif
    wait_bytes(6, 200);
    echo_valid = 1'b0;
    chk("mix_count", 32'(txq.size() >= 6), 32'd1);
    for (int i = 0; i < 6; i++) begin
      if (i < txq.size()) chk($sformatf("mix_byte%0d", i), 32'(txq[i]), 32'(exp_seq[i]));
    end
    for (int i = 0; i < 10; i++) @(negedge clk);
    chk("mix_done_once", 32'(done_cnt), 32'd1);

    // Reset while in MSG_SEND at addr 3
    clear_mem();
    for (int i = 0; i < 6; i++) mem[i] = 8'h61 + 8'(i);
    done_cnt = 0;
    pulse_start();
    found = 0;
    for (int i = 0; i < 100; i++) begin
      if (msg_addr == 10'd3 && tx_data_valid) begin
        found = 1;
        break;
      end
      @(negedge clk);
    end
    chk("abort_reached", 32'(found), 32'd1);
    tx_data_ready = 1'b0;
    dsave = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("abort_state", {29'd0, tx_data_valid, msg_busy, msg_done}, 32'd0);
    chk("abort_addr", 32'(msg_addr), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    tx_data_ready = 1'b1;
    for (int i = 0; i < 5; i++) @(negedge clk);
    chk("abort_no_done", 32'(done_cnt), 32'(dsave));
    chk("abort_idle", {30'd0, msg_busy, tx_data_valid}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
